fifo_unpack: RTL
================

Name: fifo_unpack

Overview:
- Asymmetric down-converting FIFO: the transmit-side counterpart of the team's 4-bit-in/32-bit-out flush FIFO.
- Accepts 32-bit words, each carrying 1-8 valid nibbles, and emits them one 4-bit nibble per read, LSB nibble first.
- Nibble order matches the packing side, so packed words unpack in their original order.
- Total storage is exactly 128 bits (4 word entries). Supports a discard flush and marks the final nibble of each word.

Parameters:
- depth, 4, number of 32-bit word entries (128 bits total).
- rd_width, 4, read nibble width.
- wr_width, 32, write word width.
- nibs, 8, nibbles per word (wr_width/rd_width).
- addr, $clog2(depth), word pointer index width; pointers carry one extra wrap bit.

Ports:
- clk  in  1  clock, all flops posedge.
- rst  in  1  reset: synchronous, active-high.
- wr  in  1  write strobe.
- wr_data  in  32  write word; nibble i occupies bits [4i+3:4i].
- wr_nib_cnt  in  4  valid nibbles in wr_data; legal 1-8; 0 or >8 treated as 8.
- full  out  1  all 4 word entries occupied.
- empty  out  1  no stored nibbles.
- rd  in  1  read strobe; consumes one nibble.
- rd_data  out  4  current head nibble, valid in the same cycle as rd.
- vld_rd_data  out  1  a nibble is available (equals !empty).
- rd_last  out  1  rd_data is the last valid nibble of its word.
- level  out  6  stored nibble count, 0-32.
- flush  in  1  discard all stored data (single-cycle pulse).
- flush_done  out  1  one-cycle pulse, the cycle after flush is taken.

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, nib_ptr=0, level=0, flush_done=0, storage contents don't-care. Outputs: empty=1, full=0, vld_rd_data=0, rd_data=0, rd_last=0.
- Storage:
  - Word array mem[depth] plus cnt[depth] (4-bit nibble counts).
  - wr_ptr and rd_ptr are addr+1 bits wide.
  - full = (wr_ptr[addr]!=rd_ptr[addr]) && (wr_ptr[addr-1:0]==rd_ptr[addr-1:0]).
  - empty = (wr_ptr==rd_ptr).
- Write:
  - When wr && !full: mem[wr_ptr]=wr_data, cnt[wr_ptr]=normalized count, wr_ptr+1, level += count.
  - wr while full is ignored; there is no state change and no error flag.
  - full is evaluated on pre-edge state, so a read that frees an entry in the same cycle does not admit the write.
- Read (combinational output from registered state):
  - rd_data = mem[rd_ptr][4*nib_ptr +:4] when !empty, else 0.
  - rd_last = !empty && (nib_ptr == cnt[rd_ptr]-1).
- Read consume, on rd && !empty:
  - If rd_last: rd_ptr+1, nib_ptr=0.
  - Otherwise: nib_ptr+1.
  - level -= 1.
  - rd while empty is ignored.
- No fall-through: a word written into an empty FIFO becomes readable the next cycle (write-to-vld_rd_data latency 1).
- Simultaneous rd and wr: both take effect; level += count-1.
- Flush (priority over rd):
  - flush at posedge sets rd_ptr=wr_ptr, nib_ptr=0, level=0.
  - A write in the same cycle is kept. It is written at the old wr_ptr, which becomes the new head; level=count, and empty clears the next cycle.
  - A same-cycle rd is ignored.
  - flush_done=1 for exactly the next cycle, then returns to 0.
  - flush while empty is legal and still pulses flush_done.
- Wrap-around: pointers wrap modulo 2*depth. The wrap bit distinguishes full from empty.
- rst has priority over flush, wr and rd. Reset mid-word drops all data, including a partially read word.

Decomposition:
- Package fifo_unpack_pkg holds:
  - constants DEPTH, NIBS, RD_W, WR_W;
  - typedef nib_t (logic[3:0]);
  - typedef word_t (logic[31:0]);
  - function norm_cnt(logic[3:0]) returning 1-8.
- One sub-module is natural: fifo_unpack_mem, a depth x (32+4) register array with one write port and an async read port. Pointers and level stay in the top.

Test Plan:
- Reset, then write 0x87654321 with cnt=8 → next cycle vld_rd_data=1, level=8. Eight reads give nibbles 1,2,3,4,5,6,7,8, with rd_last=1 only on the 8th; then empty=1.
- Write 0x000000AB with cnt=2, then 0xCDEF0000 with cnt=8 → reads give B, A (rd_last on A), then 0,0,0,0,F,E,D,C. level goes 2→10 and counts down to 0.
- Write 4 full words → full=1, level=32. A 5th write of 0xDEADBEEF is ignored (level stays 32). One read with a simultaneous write is still blocked (full pre-edge); level=31 after.
- Store 3 words, read 3 nibbles, then assert flush together with a write of 0x00000055, cnt=1 → next cycle flush_done=1, level=1, rd_data=5 with rd_last=1; the cycle after, flush_done=0.
- Write cnt=0 with 0x12345678 → treated as 8 nibbles. Then run 20 words interleaving rd/wr so the pointers wrap several times → the nibble stream matches the scoreboard exactly.
- Assert rst while a word is half read (nib_ptr=4) → the following cycle empty=1, level=0, rd_data=0, full=0, flush_done=0.

Source files
------------

// File: rtl/fifo_unpack_pkg.sv
// Shared constants, types and the nibble-count normalisation helper for the
// 32-bit-in / 4-bit-out unpacking FIFO.
package fifo_unpack_pkg;

  localparam int DEPTH  = 4;
  localparam int RD_W   = 4;
  localparam int WR_W   = 32;
  localparam int NIBS   = WR_W / RD_W;
  localparam int ADDR   = $clog2(DEPTH);
  localparam int CNT_W  = 4;
  localparam int NPTR_W = $clog2(NIBS);
  localparam int LVL_W  = $clog2(DEPTH * NIBS + 1);

  typedef logic [RD_W-1:0]  nib_t;
  typedef logic [WR_W-1:0]  word_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ADDR:0]    ptr_t;

  // Counts of 0 or above NIBS mean a whole word.
  function automatic cnt_t norm_cnt(input cnt_t c);
    if (c == '0 || c > CNT_W'(NIBS)) return CNT_W'(NIBS);
    return c;
  endfunction

endpackage

// File: rtl/fifo_unpack_mem.sv
// Word storage for the unpacking FIFO: one synchronous write port and one
// asynchronous read port; contents are not reset.
module fifo_unpack_mem
  import fifo_unpack_pkg::*;
#(
  parameter int depth = DEPTH,
  parameter int width = WR_W + CNT_W,
  parameter int addr  = ADDR
) (
  input  logic             clk,
  input  logic             we,
  input  logic [addr-1:0]  waddr,
  input  logic [width-1:0] wdata,
  input  logic [addr-1:0]  raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_unpack.sv
// Down-converting FIFO: stores up to four 32-bit words with per-word nibble
// counts and hands them out one nibble per read, LSB nibble first.
module fifo_unpack
  import fifo_unpack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WR_W-1:0]  wr_data,
  input  logic [CNT_W-1:0] wr_nib_cnt,
  output logic             full,
  output logic             empty,
  input  logic             rd,
  output logic [RD_W-1:0]  rd_data,
  output logic             vld_rd_data,
  output logic             rd_last,
  output logic [LVL_W-1:0] level,
  input  logic             flush,
  output logic             flush_done
);

  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic [NPTR_W-1:0] nib_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_nxt;
  logic              flush_done_q;

  word_t head_word;
  cnt_t  head_cnt;
  cnt_t  wr_cnt;
  logic  wr_take;
  logic  rd_take;

  assign wr_cnt = norm_cnt(wr_nib_cnt);

  fifo_unpack_mem #(
    .depth (DEPTH),
    .width (WR_W + CNT_W),
    .addr  (ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (wr_take),
    .waddr (wr_ptr[ADDR-1:0]),
    .wdata ({wr_cnt, wr_data}),
    .raddr (rd_ptr[ADDR-1:0]),
    .rdata ({head_cnt, head_word})
  );

  // The extra wrap bit separates a full ring from an empty one.
  assign full  = (wr_ptr[ADDR] != rd_ptr[ADDR]) &&
                 (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign vld_rd_data = !empty;
  assign level       = level_q;
  assign flush_done  = flush_done_q;

  // Flush owns the read side for the cycle, so a same-cycle read is dropped.
  assign wr_take = wr && !full;
  assign rd_take = rd && !empty && !flush;

  always_comb begin
    rd_data = '0;
    rd_last = 1'b0;
    if (!empty) begin
      rd_data = head_word[RD_W*nib_ptr +: RD_W];
      rd_last = ({1'b0, nib_ptr} == (head_cnt - CNT_W'(1)));
    end
  end

  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = wr_take ? LVL_W'(wr_cnt) : '0;
    end else begin
      if (wr_take) level_nxt = level_nxt + LVL_W'(wr_cnt);
      if (rd_take) level_nxt = level_nxt - LVL_W'(1);
    end
  end

  // A write during flush lands at the old wr_ptr, which becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      nib_ptr      <= '0;
      level_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      if (wr_take) wr_ptr <= wr_ptr + ptr_t'(1);
      if (flush) begin
        rd_ptr  <= wr_ptr;
        nib_ptr <= '0;
      end else if (rd_take) begin
        if (rd_last) begin
          rd_ptr  <= rd_ptr + ptr_t'(1);
          nib_ptr <= '0;
        end else begin
          nib_ptr <= nib_ptr + NPTR_W'(1);
        end
      end
      level_q      <= level_nxt;
      flush_done_q <= flush;
    end
  end

endmodule
